alu: RTL and testbench



---
 rtl/alu.sv | 92 +++++++++
 tb/tb_alu.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 64-bit integer ALU: combinational result/zero/overflow plus a registered copy of all three.
// Latency 0 cycles (combinational) / 1 cycle (registered); no backpressure, en gates the capture.
module alu #(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             overflow_q
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_NOR  = 4'b1100
  } alu_op_e;

  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [SHW-1:0]   shamt;
  logic             add_ovf;
  logic             sub_ovf;
  logic             lt_signed;
  logic             lt_unsigned;

  assign add_res     = a + b;
  assign sub_res     = a - b;
  assign shamt       = b[SHW-1:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;

  // Signed overflow: operand signs decide whether the result sign may legally change.
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (alu_op_e'(alu_ctrl))
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD: begin
        result   = add_res;
        overflow = add_ovf;
      end
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SUB: begin
        result   = sub_res;
        overflow = sub_ovf;
      end
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_NOR:  result = ~(a | b);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (en) begin
      result_q   <= result;
      zero_q     <= zero;
      overflow_q <= overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: table of combinational vectors plus hand-written registered-path sequences.
module tb_alu;

  localparam int W = 64;

  logic          clk;
  logic          reset;
  logic          en;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    alu_ctrl;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic [W-1:0]  result_q;
  logic          zero_q;
  logic          overflow_q;

  int tests = 0;
  int fails = 0;

  alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .a          (a),
    .b          (b),
    .alu_ctrl   (alu_ctrl),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow),
    .result_q   (result_q),
    .zero_q     (zero_q),
    .overflow_q (overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   ctrl;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX  = {1'b0, {(W-1){1'b1}}};

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0};
    vecs[1]  = '{4'b0110, 64'd20, 64'd10, 64'd10, 1'b0, 1'b0};
    vecs[2]  = '{4'b0110, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0};
    vecs[3]  = '{4'b0000, 64'd12, 64'd10, 64'd8, 1'b0, 1'b0};
    vecs[4]  = '{4'b0001, 64'd12, 64'd5, 64'd13, 1'b0, 1'b0};
    vecs[5]  = '{4'b0011, 64'd12, 64'd10, 64'd6, 1'b0, 1'b0};
    vecs[6]  = '{4'b1100, 64'd0, 64'd0, ONES, 1'b0, 1'b0};
    vecs[7]  = '{4'b0100, 64'd3, 64'd1, 64'd6, 1'b0, 1'b0};
    vecs[8]  = '{4'b0101, 64'd8, 64'd1, 64'd4, 1'b0, 1'b0};
    vecs[9]  = '{4'b1001, 64'hFFFF_FFFF_FFFF_FFF8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0};
    vecs[10] = '{4'b0100, 64'd3, 64'h41, 64'd6, 1'b0, 1'b0};
    vecs[11] = '{4'b0111, ONES, 64'd1, 64'd1, 1'b0, 1'b0};
    vecs[12] = '{4'b1000, ONES, 64'd1, 64'd0, 1'b1, 1'b0};
    vecs[13] = '{4'b0010, MAX, 64'd1, MIN, 1'b0, 1'b1};
    vecs[14] = '{4'b1111, 64'd5, 64'd3, 64'd0, 1'b1, 1'b0};
    vecs[15] = '{4'b0110, MIN, 64'd1, MAX, 1'b0, 1'b1};
    vecs[16] = '{4'b0111, MIN, 64'd0, 64'd1, 1'b0, 1'b0};
    vecs[17] = '{4'b1001, MIN, 64'd63, ONES, 1'b0, 1'b0};
    vecs[18] = '{4'b0010, ONES, 64'd1, 64'd0, 1'b1, 1'b0};
    vecs[19] = '{4'b0101, ONES, 64'd63, 64'd1, 1'b0, 1'b0};
    vecs[20] = '{4'b1001, 64'h8000_0000_0000_0001, 64'd64, 64'h8000_0000_0000_0001, 1'b0, 1'b0};
    vecs[21] = '{4'b1010, ONES, ONES, 64'd0, 1'b1, 1'b0};
    vecs[22] = '{4'b0110, 64'd0, MIN, MIN, 1'b0, 1'b1};

    reset    = 1'b1;
    en       = 1'b0;
    a        = '0;
    b        = '0;
    alu_ctrl = 4'b0000;

    // Registered path: reset, capture, hold, capture flags, reset over enable.
    @(posedge clk); #1;
    check("rst_result_q", result_q, 64'd0);
    check("rst_zero_q", {63'd0, zero_q}, 64'd0);
    check("rst_overflow_q", {63'd0, overflow_q}, 64'd0);

    reset = 1'b0; en = 1'b1; a = 64'd10; b = 64'd20; alu_ctrl = 4'b0010;
    #1;
    check("pre_edge_result_q", result_q, 64'd0);
    @(posedge clk); #1;
    check("cap_result_q", result_q, 64'd30);
    check("cap_zero_q", {63'd0, zero_q}, 64'd0);

    en = 1'b0; a = 64'd5; b = 64'd5; alu_ctrl = 4'b0110;
    @(posedge clk); #1;
    check("hold_result_q", result_q, 64'd30);
    check("hold_zero_q", {63'd0, zero_q}, 64'd0);

    en = 1'b1;
    @(posedge clk); #1;
    check("cap_sub_result_q", result_q, 64'd0);
    check("cap_sub_zero_q", {63'd0, zero_q}, 64'd1);

    a = MAX; b = 64'd1; alu_ctrl = 4'b0010;
    @(posedge clk); #1;
    check("cap_ovf_result_q", result_q, MIN);
    check("cap_ovf_overflow_q", {63'd0, overflow_q}, 64'd1);

    reset = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    check("rst_en_result_q", result_q, 64'd0);
    check("rst_en_zero_q", {63'd0, zero_q}, 64'd0);
    check("rst_en_overflow_q", {63'd0, overflow_q}, 64'd0);

    reset = 1'b0; en = 1'b0;

    for (int i = 0; i < NV; i++) begin
      a        = vecs[i].va;
      b        = vecs[i].vb;
      alu_ctrl = vecs[i].ctrl;
      #1;
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].z});
      check($sformatf("vec%0d_overflow", i), {63'd0, overflow}, {63'd0, vecs[i].ov});
    end

    // Registered outputs still held from the reset since en stayed low.
    @(posedge clk); #1;
    check("final_hold_result_q", result_q, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
